// File: rtl/adc_event_readout_ctrl.sv
// adc_event_readout_ctrl: walks the ADC event buffer from the top row down and serialises each row onto a valid/ready stream.
// Define ADC_EVT_HEADER_EN to prefix every event with a header beat.
module adc_event_readout_ctrl #(
  parameter int DEPTH = 64,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 768,
  parameter int OUT_W = 64,
  parameter int RD_LATENCY = 2
) (
  input  logic              rd_clk,
  input  logic              rst_n,
  input  logic              evt_done,
  input  logic [ADDR_W:0]   n_samples,
  output logic [ADDR_W-1:0] read_addr,
  input  logic [DATA_W-1:0] buf_data_in,
  output logic [OUT_W-1:0]  m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_first,
  output logic              m_last,
  output logic              busy,
  output logic [15:0]       evt_cnt,
  output logic [15:0]       drop_cnt
);
  localparam int BEATS = DATA_W / OUT_W;
  localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam int LW = RD_LATENCY > 1 ? $clog2(RD_LATENCY) : 1;
  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] TOP = ADDR_W'(DEPTH - 1);
`ifdef ADC_EVT_HEADER_EN
  typedef enum logic [2:0] {IDLE, HDR, FETCH, WAIT, SHIFT} state_t;
  localparam state_t START = HDR;
`else
  typedef enum logic [1:0] {IDLE, FETCH, WAIT, SHIFT} state_t;
  localparam state_t START = FETCH;
`endif
  state_t state, state_n;
  logic [ADDR_W:0] rem;
  logic [LW-1:0] wcnt;
  logic [BW-1:0] beat;
  logic [DATA_W-1:0] sreg;
  logic last_row, row_end;
  always_ff @(posedge rd_clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
`ifdef ADC_EVT_HEADER_EN
    m_valid = state == SHIFT || state == HDR;
    m_first = state == HDR;
    m_data = state == HDR ? OUT_W'({9'h1A5, 7'(rem), evt_cnt}) : state == SHIFT ? sreg[OUT_W-1:0] : '0;
`else
    m_valid = state == SHIFT;
    m_first = state == SHIFT && read_addr == TOP && beat == '0;
    m_data = state == SHIFT ? sreg[OUT_W-1:0] : '0;
`endif
    last_row = rem == (ADDR_W+1)'(1);
    m_last = state == SHIFT && last_row && beat == BW'(BEATS - 1);
    busy = state != IDLE;
    row_end = state == SHIFT && m_ready && beat == BW'(BEATS - 1);
    state_n = state;
    case (state)
      IDLE: state_n = evt_done ? START : IDLE;
`ifdef ADC_EVT_HEADER_EN
      HDR: state_n = m_ready ? FETCH : HDR;
`endif
      FETCH: state_n = WAIT;
      WAIT: state_n = wcnt == '0 ? SHIFT : WAIT;
      SHIFT: state_n = row_end ? (last_row ? IDLE : FETCH) : SHIFT;
      default: state_n = IDLE;
    endcase
  end
  // The first row is always the top address, so m_first needs no extra flag.
  always_ff @(posedge rd_clk) begin
    if (!rst_n) begin
      read_addr <= TOP;
      rem <= '0;
      wcnt <= '0;
      beat <= '0;
      sreg <= '0;
      evt_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      if (state == IDLE && evt_done) begin
        rem <= (n_samples == '0 || n_samples > FULL) ? FULL : n_samples;
        evt_cnt <= evt_cnt + 16'd1;
      end
      if (state != IDLE && evt_done && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      wcnt <= state == FETCH ? LW'(RD_LATENCY - 1) : wcnt - LW'(1);
      if (state == WAIT && wcnt == '0) begin
        sreg <= buf_data_in;
        beat <= '0;
      end else if (state == SHIFT && m_ready) begin
        sreg <= sreg >> OUT_W;
        beat <= beat + BW'(1);
      end
      if (row_end) begin
        rem <= rem - (ADDR_W+1)'(1);
        read_addr <= last_row ? TOP : read_addr - ADDR_W'(1);
      end
    end
  end
endmodule
